// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered 8N1 UART transmitter.
//   Bytes enter a FIFO over a valid/ready handshake and are serialised LSB-first
//   on UART_TX at BAUD. UART_CTS (active-low) gates the start of each frame only.
// Ports:
//   CLK_50M     system clock (rising edge)
//   FPGA_RST    asynchronous active-high reset
//   TX_Data     byte to transmit
//   TX_Valid    TX_Data valid
//   TX_Ready    FIFO not full
//   UART_CTS    peer clear-to-send, active-low, asynchronous
//   UART_TX     serial line, idles high, driven from a flop
//   TX_Busy     frame on the line or bytes buffered
//   FIFO_Count  bytes currently buffered
module uart_tx_buffered #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                         CLK_50M,
  input  logic                         FPGA_RST,
  input  logic [7:0]                   TX_Data,
  input  logic                         TX_Valid,
  output logic                         TX_Ready,
  input  logic                         UART_CTS,
  output logic                         UART_TX,
  output logic                         TX_Busy,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_Count
);

  localparam int unsigned DIVISOR = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned PW      = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // FIFO storage and pointers
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    head_byte;

  // CTS synchroniser
  logic cts_meta_q;
  logic cts_sync_q;
  logic cts_ok;

  // Transmit FSM
  state_e         state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           line_busy_q;
  logic           baud_done;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == PW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign head_byte = mem_q[rd_ptr_q[AW-1:0]];
  assign push      = TX_Valid && !full;

  assign wr_ptr_d = wr_ptr_q + PW'(push);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);

  always_ff @(posedge CLK_50M or posedge FPGA_RST) begin
    if (FPGA_RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= TX_Data;
    end
  end

  // ---------------------------------------------------------------------------
  // CTS synchroniser (reset to "not clear")
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_50M or posedge FPGA_RST) begin
    if (FPGA_RST) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= UART_CTS;
      cts_sync_q <= cts_meta_q;
    end
  end

  assign cts_ok = !cts_sync_q;

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  assign baud_done = (baud_cnt_q == CNT_W'(DIVISOR - 1));

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    tx_d       = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        tx_d       = 1'b1;
        baud_cnt_d = '0;
        if (!empty && cts_ok) begin
          pop     = 1'b1;
          shift_d = head_byte;
          state_d = S_START;
        end
      end

      S_START: begin
        tx_d = 1'b0;
        if (baud_done) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        tx_d = shift_q[0];
        if (baud_done) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (baud_done) begin
          baud_cnt_d = '0;
          if (!empty && cts_ok) begin
            pop     = 1'b1;
            shift_d = head_byte;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d    = S_IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_50M or posedge FPGA_RST) begin
    if (FPGA_RST) begin
      state_q     <= S_IDLE;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      line_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      line_busy_q <= (state_q != S_IDLE);
    end
  end

  // The line lags the FSM by one flop; line_busy_q holds TX_Busy until the
  // last stop bit has actually left UART_TX.
  assign UART_TX    = tx_q;
  assign TX_Ready   = !full;
  assign TX_Busy    = (state_q != S_IDLE) || !empty || line_busy_q;
  assign FIFO_Count = count;

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

  localparam int D = 16;  // (1_000_000 + 31_250) / 62_500

  logic       clk;
  logic       rst;
  logic [7:0] TX_Data;
  logic       TX_Valid;
  logic       TX_Ready;
  logic       UART_CTS;
  logic       UART_TX;
  logic       TX_Busy;
  logic [4:0] FIFO_Count;

  int checks   = 0;
  int failures = 0;

  uart_tx_buffered #(
    .CLK_FREQ  (1000000),
    .BAUD      (62500),
    .FIFO_DEPTH(16)
  ) dut (
    .CLK_50M   (clk),
    .FPGA_RST  (rst),
    .TX_Data   (TX_Data),
    .TX_Valid  (TX_Valid),
    .TX_Ready  (TX_Ready),
    .UART_CTS  (UART_CTS),
    .UART_TX   (UART_TX),
    .TX_Busy   (TX_Busy),
    .FIFO_Count(FIFO_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // All stimulus and sampling happens on falling edges.
  task automatic push_byte(input logic [7:0] b);
    TX_Data  = b;
    TX_Valid = 1'b1;
    @(negedge clk);
    TX_Valid = 1'b0;
  endtask

  task automatic wait_fall(input int limit, output bit ok, output int n);
    n = 0;
    while (UART_TX !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    ok = (UART_TX === 1'b0);
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int n;
    n = 0;
    while (TX_Busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    ok = (TX_Busy === 1'b0);
  endtask

  // Called on the first falling edge that sees the start bit; returns mid stop bit.
  task automatic rx_frame(input int cts_at, output logic [7:0] data, output bit fr_ok);
    fr_ok = 1'b1;
    repeat (D / 2) @(negedge clk);
    if (UART_TX !== 1'b0) fr_ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (D) @(negedge clk);
      data[i] = UART_TX;
      if (i == cts_at) UART_CTS = 1'b1;
    end
    repeat (D) @(negedge clk);
    if (UART_TX !== 1'b1) fr_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    TX_Valid = 1'b0;
    TX_Data  = '0;
    UART_CTS = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (UART_TX !== 1'b1) begin failures++; $display("FAIL rst_tx UART_TX=%b expected 1", UART_TX); end
    checks++; if (TX_Ready !== 1'b1) begin failures++; $display("FAIL rst_ready TX_Ready=%b expected 1", TX_Ready); end
    checks++; if (TX_Busy !== 1'b0) begin failures++; $display("FAIL rst_busy TX_Busy=%b expected 0", TX_Busy); end
    checks++; if (FIFO_Count !== 5'd0) begin failures++; $display("FAIL rst_count FIFO_Count=%0d expected 0", FIFO_Count); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [9:0] frame;
    int         errs;
    logic       busy_last;
    frame = {1'b1, 8'h55, 1'b0};
    errs  = 0;
    UART_CTS = 1'b0;
    repeat (4) @(negedge clk);
    push_byte(8'h55);
    checks++; if (UART_TX !== 1'b1) begin failures++; $display("FAIL t1_lat0 UART_TX=%b expected 1", UART_TX); end
    @(negedge clk);
    checks++; if (UART_TX !== 1'b1) begin failures++; $display("FAIL t1_lat1 UART_TX=%b expected 1", UART_TX); end
    @(negedge clk);
    checks++; if (UART_TX !== 1'b0) begin failures++; $display("FAIL t1_lat2 UART_TX=%b expected 0", UART_TX); end
    busy_last = 1'b0;
    for (int k = 0; k < 10 * D; k++) begin
      if (UART_TX !== frame[k / D]) errs++;
      if (k == 10 * D - 1) busy_last = TX_Busy;
      @(negedge clk);
    end
    checks++; if (errs != 0) begin failures++; $display("FAIL t1_waveform bad_samples=%0d expected 0", errs); end
    checks++; if (busy_last !== 1'b1) begin failures++; $display("FAIL t1_busy_end TX_Busy=%b expected 1", busy_last); end
    checks++; if (TX_Busy !== 1'b0) begin failures++; $display("FAIL t1_busy_drop TX_Busy=%b expected 0", TX_Busy); end
    checks++; if (UART_TX !== 1'b1) begin failures++; $display("FAIL t1_idle UART_TX=%b expected 1", UART_TX); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3];
    logic [7:0] d;
    bit         ok, fok;
    int         n;
    exp_b[0] = 8'hA3; exp_b[1] = 8'h0F; exp_b[2] = 8'hFF;
    TX_Valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      TX_Data = exp_b[i];
      @(negedge clk);
    end
    TX_Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_fall(2 * D, ok, n);
      checks++; if (!ok) begin failures++; $display("FAIL t2_start%0d no start bit within %0d clocks", i, 2 * D); end
      if (i > 0) begin
        checks++; if (n != D / 2) begin failures++; $display("FAIL t2_gap%0d clocks=%0d expected %0d", i, n, D / 2); end
      end
      rx_frame(-1, d, fok);
      checks++; if (d !== exp_b[i] || !fok) begin failures++; $display("FAIL t2_byte%0d got=%h framing=%0d expected %h framing=1", i, d, fok, exp_b[i]); end
    end
    wait_idle(4 * D, ok);
    checks++; if (!ok) begin failures++; $display("FAIL t2_idle TX_Busy=%b expected 0", TX_Busy); end
  endtask

  task automatic test_cts_holdoff();
    logic [7:0] d;
    bit         ok, fok, high;
    int         n;
    UART_CTS = 1'b1;
    repeat (4) @(negedge clk);
    high = 1'b1;
    TX_Valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      TX_Data = 8'(16 + i);
      @(negedge clk);
      if (UART_TX !== 1'b1) high = 1'b0;
    end
    TX_Valid = 1'b0;
    repeat (2 * D) begin
      @(negedge clk);
      if (UART_TX !== 1'b1) high = 1'b0;
    end
    checks++; if (TX_Ready !== 1'b0) begin failures++; $display("FAIL t3_ready TX_Ready=%b expected 0", TX_Ready); end
    checks++; if (FIFO_Count !== 5'd16) begin failures++; $display("FAIL t3_count FIFO_Count=%0d expected 16", FIFO_Count); end
    checks++; if (!high) begin failures++; $display("FAIL t3_line_held UART_TX moved while CTS=1, expected constant 1"); end
    checks++; if (TX_Busy !== 1'b1) begin failures++; $display("FAIL t3_busy TX_Busy=%b expected 1", TX_Busy); end
    UART_CTS = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wait_fall(2 * D, ok, n);
      checks++; if (!ok) begin failures++; $display("FAIL t3_start%0d no start bit within %0d clocks", i, 2 * D); end
      rx_frame(-1, d, fok);
      checks++; if (d !== 8'(16 + i) || !fok) begin failures++; $display("FAIL t3_byte%0d got=%h framing=%0d expected %h framing=1", i, d, fok, 8'(16 + i)); end
    end
    wait_idle(4 * D, ok);
    checks++; if (!ok || FIFO_Count !== 5'd0) begin failures++; $display("FAIL t3_drain TX_Busy=%b FIFO_Count=%0d expected 0 and 0", TX_Busy, FIFO_Count); end
  endtask

  task automatic test_cts_midframe();
    logic [7:0] d;
    bit         ok, fok, high;
    int         n;
    UART_CTS = 1'b0;
    TX_Valid = 1'b1;
    TX_Data  = 8'h81;
    @(negedge clk);
    TX_Data  = 8'h42;
    @(negedge clk);
    TX_Valid = 1'b0;
    wait_fall(2 * D, ok, n);
    checks++; if (!ok) begin failures++; $display("FAIL t4_start no start bit within %0d clocks", 2 * D); end
    rx_frame(3, d, fok);
    checks++; if (d !== 8'h81 || !fok) begin failures++; $display("FAIL t4_byte81 got=%h framing=%0d expected 81 framing=1", d, fok); end
    high = 1'b1;
    repeat (5 * D) begin
      @(negedge clk);
      if (UART_TX !== 1'b1) high = 1'b0;
    end
    checks++; if (!high) begin failures++; $display("FAIL t4_held queued frame started while CTS=1"); end
    checks++; if (FIFO_Count !== 5'd1) begin failures++; $display("FAIL t4_count FIFO_Count=%0d expected 1", FIFO_Count); end
    UART_CTS = 1'b0;
    wait_fall(10, ok, n);
    checks++; if (!ok || n > 4) begin failures++; $display("FAIL t4_release start after %0d clocks expected <= 4", n); end
    rx_frame(-1, d, fok);
    checks++; if (d !== 8'h42 || !fok) begin failures++; $display("FAIL t4_byte42 got=%h framing=%0d expected 42 framing=1", d, fok); end
    wait_idle(4 * D, ok);
    checks++; if (!ok) begin failures++; $display("FAIL t4_idle TX_Busy=%b expected 0", TX_Busy); end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] d;
    bit         ok, fok;
    int         n;
    // Part 1: full FIFO with a frame in flight; push attempted on the pop edge.
    UART_CTS = 1'b0;
    TX_Valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      TX_Data = 8'(96 + i);
      @(negedge clk);
    end
    TX_Data = 8'hEE;
    checks++; if (FIFO_Count !== 5'd16 || TX_Ready !== 1'b0) begin failures++; $display("FAIL t5_full FIFO_Count=%0d TX_Ready=%b expected 16 and 0", FIFO_Count, TX_Ready); end
    n = 0;
    while (FIFO_Count === 5'd16 && n < 12 * D) begin
      @(negedge clk);
      n++;
    end
    TX_Valid = 1'b0;
    checks++; if (FIFO_Count !== 5'd15) begin failures++; $display("FAIL t5_full_pop FIFO_Count=%0d expected 15", FIFO_Count); end
    for (int i = 1; i <= 16; i++) begin
      wait_fall(2 * D, ok, n);
      checks++; if (!ok) begin failures++; $display("FAIL t5_start%0d no start bit within %0d clocks", i, 2 * D); end
      rx_frame(-1, d, fok);
      checks++; if (d !== 8'(96 + i) || !fok) begin failures++; $display("FAIL t5_byte%0d got=%h framing=%0d expected %h framing=1", i, d, fok, 8'(96 + i)); end
    end
    wait_idle(4 * D, ok);
    checks++; if (!ok || FIFO_Count !== 5'd0) begin failures++; $display("FAIL t5_drain TX_Busy=%b FIFO_Count=%0d expected 0 and 0", TX_Busy, FIFO_Count); end

    // Part 2: count 8, push coincides with the STOP->START pop.
    push_byte(8'h90);
    wait_fall(2 * D, ok, n);
    checks++; if (!ok) begin failures++; $display("FAIL t5b_start no start bit within %0d clocks", 2 * D); end
    TX_Valid = 1'b1;
    for (int j = 0; j < 8; j++) begin
      TX_Data = 8'(8'h91 + j);
      @(negedge clk);
    end
    TX_Valid = 1'b0;
    repeat (10 * D - 2 - 8) @(negedge clk);
    checks++; if (FIFO_Count !== 5'd8) begin failures++; $display("FAIL t5b_pre FIFO_Count=%0d expected 8", FIFO_Count); end
    TX_Data  = 8'h99;
    TX_Valid = 1'b1;
    @(negedge clk);
    TX_Valid = 1'b0;
    checks++; if (FIFO_Count !== 5'd8) begin failures++; $display("FAIL t5b_pushpop FIFO_Count=%0d expected 8", FIFO_Count); end
    for (int i = 0; i < 9; i++) begin
      wait_fall(2 * D, ok, n);
      checks++; if (!ok) begin failures++; $display("FAIL t5b_start%0d no start bit within %0d clocks", i, 2 * D); end
      rx_frame(-1, d, fok);
      checks++; if (d !== 8'(8'h91 + i) || !fok) begin failures++; $display("FAIL t5b_byte%0d got=%h framing=%0d expected %h framing=1", i, d, fok, 8'(8'h91 + i)); end
    end
    wait_idle(4 * D, ok);
    checks++; if (!ok || FIFO_Count !== 5'd0) begin failures++; $display("FAIL t5b_drain TX_Busy=%b FIFO_Count=%0d expected 0 and 0", TX_Busy, FIFO_Count); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    bit         ok, fok;
    int         n;
    UART_CTS = 1'b0;
    push_byte(8'hC1);
    wait_fall(2 * D, ok, n);
    checks++; if (!ok) begin failures++; $display("FAIL t6_start no start bit within %0d clocks", 2 * D); end
    TX_Valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      TX_Data = 8'(8'hC2 + j);
      @(negedge clk);
    end
    TX_Valid = 1'b0;
    repeat (6 * D + D / 2 - 3) @(negedge clk);
    checks++; if (UART_TX !== 1'b0 || FIFO_Count !== 5'd3) begin failures++; $display("FAIL t6_pre UART_TX=%b FIFO_Count=%0d expected 0 and 3", UART_TX, FIFO_Count); end
    rst = 1'b1;
    #1;
    checks++; if (UART_TX !== 1'b1) begin failures++; $display("FAIL t6_rst_tx UART_TX=%b expected 1", UART_TX); end
    checks++; if (FIFO_Count !== 5'd0) begin failures++; $display("FAIL t6_rst_count FIFO_Count=%0d expected 0", FIFO_Count); end
    checks++; if (TX_Busy !== 1'b0) begin failures++; $display("FAIL t6_rst_busy TX_Busy=%b expected 0", TX_Busy); end
    checks++; if (TX_Ready !== 1'b1) begin failures++; $display("FAIL t6_rst_ready TX_Ready=%b expected 1", TX_Ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_fall(12 * D, ok, n);
    checks++; if (ok) begin failures++; $display("FAIL t6_stale start bit seen %0d clocks after reset, expected none", n); end
    push_byte(8'h3C);
    wait_fall(2 * D, ok, n);
    checks++; if (!ok || n != 2) begin failures++; $display("FAIL t6_lat start after %0d clocks expected 2", n); end
    rx_frame(-1, d, fok);
    checks++; if (d !== 8'h3C || !fok) begin failures++; $display("FAIL t6_byte3c got=%h framing=%0d expected 3c framing=1", d, fok); end
    wait_idle(4 * D, ok);
    checks++; if (!ok) begin failures++; $display("FAIL t6_idle TX_Busy=%b expected 0", TX_Busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_cts_holdoff();
    test_cts_midframe();
    test_full_pushpop();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
